// File: rtl/lfsr32_if.sv
// lfsr32_if: LFSR control/data bus; master drives INIT, GO, SEED and reads Q, slave is the LFSR
interface lfsr32_if #(parameter int N = 32);
  logic         INIT;
  logic         GO;
  logic [N-1:0] SEED;
  logic [N-1:0] Q;
  modport master (output INIT, GO, SEED, input Q);
  modport slave (input INIT, GO, SEED, output Q);
endinterface

// File: rtl/lfsr32.sv
// lfsr32: 32-bit Fibonacci right-shift LFSR; ports CLK, RST (async active-high), bus.slave {INIT, GO, SEED -> Q}; define LFSR32_LOCKUP_GUARD_EN to force fb=1 from the all-zero state
module lfsr32 #(
  parameter int           N           = 32,
  parameter logic [N-1:0] TAPS        = 32'h8020_0003,
  parameter logic [N-1:0] RESET_VALUE = 32'h0000_0001
) (
  input logic     CLK,
  input logic     RST,
  lfsr32_if.slave bus
);
  logic [N-1:0] q_q, q_d;
  logic         fb;
  always_comb begin
`ifdef LFSR32_LOCKUP_GUARD_EN
    fb = ~|q_q | ^(q_q & TAPS);
`else
    fb = ^(q_q & TAPS);
`endif
    q_d = bus.INIT ? bus.SEED : bus.GO ? {fb, q_q[N-1:1]} : q_q;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) q_q <= RESET_VALUE;
    else q_q <= q_d;
  assign bus.Q = q_q;
endmodule

// File: tb/tb_lfsr32.sv
// tb_lfsr32: directed self-checking bench for lfsr32
module tb_lfsr32;
  localparam logic [31:0] TAPS = 32'h8020_0003;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int tests = 0;
  int errs = 0;
  logic [31:0] r, s;
  lfsr32_if #(32) bus ();
  lfsr32 dut (.CLK(CLK), .RST(RST), .bus(bus));
  always #5 CLK = ~CLK;
  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task apply(input logic i, input logic g, input logic [31:0] sd);
    bus.INIT = i;
    bus.GO = g;
    bus.SEED = sd;
    @(posedge CLK);
    @(negedge CLK);
    bus.INIT = 1'b0;
    bus.GO = 1'b0;
  endtask
  initial begin
    bus.INIT = 1'b0;
    bus.GO = 1'b0;
    bus.SEED = '0;
    #1 RST = 1'b1;
    #1 chk("reset_async", bus.Q, 32'h0000_0001);
    @(negedge CLK);
    @(negedge CLK);
    chk("reset_hold", bus.Q, 32'h0000_0001);
    RST = 1'b0;
    apply(1, 0, 32'h1234_5678);
    chk("load_a", bus.Q, 32'h1234_5678);
    apply(0, 0, 32'h0);
    chk("load_a_idle", bus.Q, 32'h1234_5678);
    apply(1, 0, 32'h0000_0000);
    chk("load_zero", bus.Q, 32'h0000_0000);
    apply(1, 0, 32'h9ABC_DEF0);
    chk("load_b", bus.Q, 32'h9ABC_DEF0);
    r = $urandom;
    apply(1, 0, r);
    chk("load_rand", bus.Q, r);
    apply(1, 0, 32'h1234_5678);
    apply(0, 1, 32'h0);
    chk("step_a", bus.Q, 32'h891A_2B3C);
    chk("step_shift", bus.Q << 1, 32'h1234_5678 & ~32'h1);
    s = $urandom;
    apply(1, 0, s);
    apply(0, 1, 32'h0);
    chk("step_rand", bus.Q, {^(s & TAPS), s[31:1]});
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, $urandom);
      chk("storage", bus.Q, {^(s & TAPS), s[31:1]});
    end
    apply(1, 1, 32'hA5A5_A5A5);
    chk("priority", bus.Q, 32'hA5A5_A5A5);
    apply(1, 0, 32'h0000_0001);
    apply(0, 1, 32'h0);
    chk("walk_1", bus.Q, 32'h8000_0000);
    apply(0, 1, 32'h0);
    chk("walk_2", bus.Q, 32'hC000_0000);
    apply(0, 1, 32'h0);
    chk("walk_3", bus.Q, 32'hE000_0000);
    bus.GO = 1'b1;
    @(posedge CLK);
    #3 RST = 1'b1;
    #1 chk("reset_mid", bus.Q, 32'h0000_0001);
    bus.INIT = 1'b1;
    bus.SEED = 32'hFFFF_FFFF;
    @(negedge CLK);
    @(negedge CLK);
    chk("reset_ignore", bus.Q, 32'h0000_0001);
    bus.INIT = 1'b0;
    bus.GO = 1'b0;
    RST = 1'b0;
    apply(0, 1, 32'h0);
    chk("reset_go", bus.Q, 32'h8000_0000);
    apply(1, 0, 32'h0000_0000);
    apply(0, 1, 32'h0);
`ifdef LFSR32_LOCKUP_GUARD_EN
    chk("lockup", bus.Q, 32'h8000_0000);
`else
    chk("lockup", bus.Q, 32'h0000_0000);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end
endmodule

// File: doc/lfsr32.md
LFSR32 -- requirements
Module: lfsr32

Interface
REQ-001 SHALL have parameter N, default 32, register width; only N=32 is supported.
REQ-002 SHALL have parameter TAPS, default 32'h8020_0003, feedback tap mask (bits 31,21,1,0; x^32+x^22+x^2+x+1).
REQ-003 SHALL have parameter RESET_VALUE, default 32'h0000_0001, the value Q takes on reset.
REQ-004 SHALL have port CLK, input, 1 bit, the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port RST, input, 1 bit, asynchronous active-high reset.
REQ-006 SHALL have port INIT, input, 1 bit, synchronous seed-load request.
REQ-007 SHALL have port GO, input, 1 bit, single-step advance enable.
REQ-008 SHALL have port SEED, input, N bits, load value used when INIT=1.
REQ-009 SHALL have port Q, output, N bits, current register state, driven directly from the register.

Function
REQ-010 SHALL implement a Fibonacci right-shift LFSR: fb = XOR-reduce(Q & TAPS); next Q = {fb, Q[N-1:1]}.
REQ-011 SHALL load Q <= SEED on a rising CLK edge with INIT=1, regardless of GO.
REQ-012 SHALL advance exactly one step per rising CLK edge with INIT=0 and GO=1.
REQ-013 SHALL hold Q unchanged on a rising CLK edge with INIT=0 and GO=0 (storage mode), for any number of cycles.
REQ-014 SHALL give INIT priority over GO when both are 1 in the same cycle.
REQ-015 SHALL make a loaded or advanced value visible on Q one clock edge after the request (latency 1), with no additional pipeline stage.
REQ-016 SHALL accept any SEED value, including all-zero; a loaded seed SHALL read back unchanged on Q.
REQ-017 SHALL, after one GO step from state S, satisfy Q[N-2:0] = S[N-1:1], with Q[N-1] = fb(S).
REQ-018 SHALL keep Q stable between clock edges; INIT, GO and SEED are sampled only at rising CLK edges.
REQ-019 SHALL have period 2^32-1 over all non-zero states with the default TAPS.

Reset
REQ-020 SHALL set Q to RESET_VALUE immediately when RST rises, independent of CLK.
REQ-021 SHALL hold Q at RESET_VALUE while RST=1, ignoring INIT and GO.
REQ-022 SHALL resume normal operation on the first rising CLK edge after RST falls.
REQ-023 SHALL abort any step or load in progress when RST is asserted mid-operation, with no partial update.

Configuration
REQ-024 SHALL support macro LFSR32_LOCKUP_GUARD_EN.
REQ-025 SHALL, with LFSR32_LOCKUP_GUARD_EN defined and Q=0 on a GO step, force fb=1 so that next Q = 32'h8000_0000.
REQ-026 SHALL, without LFSR32_LOCKUP_GUARD_EN, remain all-zero on GO steps from Q=0 (standard lock-up state).
REQ-027 SHALL leave INIT loads unaffected by LFSR32_LOCKUP_GUARD_EN; a zero SEED still loads as 0.

Verification
REQ-028 SHALL cover load: SEED=0x12345678, INIT pulse of one cycle, then idle -> Q=0x12345678; repeat with 0x00000000, 0x9ABCDEF0 and a random value.
REQ-029 SHALL cover step: load 0x12345678, one-cycle GO pulse -> Q=0x891A2B3C; Q<<1 with LSB cleared equals the seed with LSB cleared.
REQ-030 SHALL cover storage: load a random seed, one GO pulse, then GO=0 for 2+ cycles -> Q identical on every sampled cycle.
REQ-031 SHALL cover priority: INIT=1 and GO=1 together with SEED=0xA5A5A5A5 -> Q=0xA5A5A5A5 (no shift).
REQ-032 SHALL cover reset: assert RST asynchronously mid-GO-stream -> Q=0x00000001 immediately and held while RST=1; the first GO after release -> Q=0x80000000.
REQ-033 SHALL cover lockup: load 0, GO -> Q=0x80000000 with LFSR32_LOCKUP_GUARD_EN defined, and Q=0x00000000 without it.
